// File: rtl/day13_serial_readout.sv
// Parallel-to-serial readout, MSB first; ser_valid rises 1 cycle after load, and back-to-back words run with no gap.
// Backpressure: ser_ready=0 holds the current bit stable; a load while a word is still in flight is dropped and flagged on overrun.
module day13_serial_readout #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_data,
    output logic             ser_last,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             overrun_q;
    // Cleared by reset, set on the first edge afterwards, so the edge that
    // coincides with reset release can never capture a word.
    logic             armed;

    logic in_shift;
    logic at_last;
    logic xfer;

    assign in_shift = (state == ST_SHIFT);
    assign at_last  = (cnt == LAST_IDX);
    assign xfer     = in_shift && ser_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            cnt       <= '0;
            overrun_q <= 1'b0;
            armed     <= 1'b0;
        end else begin
            armed     <= 1'b1;
            overrun_q <= in_shift && load && !(xfer && at_last);
            if (!in_shift) begin
                if (load && armed) begin
                    sreg  <= din;
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
            end else if (xfer) begin
                if (at_last) begin
                    cnt <= '0;
                    if (load) begin
                        sreg <= din;
                    end else begin
                        sreg  <= '0;
                        state <= ST_IDLE;
                    end
                end else begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                    cnt  <= cnt + CW'(1);
                end
            end
        end
    end

    assign ser_valid = in_shift;
    assign busy      = in_shift;
    assign ser_data  = in_shift && sreg[WIDTH-1];
    assign ser_last  = in_shift && at_last;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_day13_serial_readout.sv
// Directed bench for day13_serial_readout: WIDTH=8 instance plus a WIDTH=2 instance.
module tb_day13_serial_readout;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load, load2;
    logic [7:0] din;
    logic [1:0] din2;
    logic       ser_ready, ser_ready2;
    logic       ser_valid, ser_data, ser_last, busy, overrun;
    logic       ser_valid2, ser_data2, ser_last2, busy2, overrun2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    day13_serial_readout #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .ser_ready(ser_ready),
        .ser_valid(ser_valid), .ser_data(ser_data), .ser_last(ser_last),
        .busy(busy), .overrun(overrun)
    );

    day13_serial_readout #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .load(load2), .din(din2), .ser_ready(ser_ready2),
        .ser_valid(ser_valid2), .ser_data(ser_data2), .ser_last(ser_last2),
        .busy(busy2), .overrun(overrun2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_outs"}, {27'd0, ser_valid, ser_data, ser_last, busy, overrun}, 32'd0);
    endtask

    initial begin
        logic [7:0]  w;
        logic [15:0] w16;
        logic [7:0]  acc;
        int          nacc;
        logic        pv, pr, pd, pl;

        rst_n = 1'b0; load = 1'b0; din = '0; ser_ready = 1'b0;
        load2 = 1'b0; din2 = '0; ser_ready2 = 1'b0;
        #3;
        chk_idle("reset");
        chk("reset_w2", {28'd0, ser_valid2, ser_data2, ser_last2, busy2}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ready asserted while idle does nothing
        ser_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk_idle("idle_ready");

        // A5 with ready held high
        w = 8'hA5; load = 1'b1; din = w;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            load = 1'b0; din = 8'h00;
            chk($sformatf("a5_valid%0d", i), ser_valid, 1'b1);
            chk($sformatf("a5_data%0d", i), ser_data, w[7-i]);
            chk($sformatf("a5_last%0d", i), ser_last, (i == 7));
            chk($sformatf("a5_busy%0d", i), busy, 1'b1);
        end
        @(negedge clk);
        chk_idle("a5_after");

        // C3 with ready pattern 1,0,0 repeating
        ser_ready = 1'b0; load = 1'b1; din = 8'hC3;
        acc = '0; nacc = 0; pv = 1'b0; pr = 1'b0; pd = 1'b0; pl = 1'b0;
        for (int k = 0; k < 60 && nacc < 8; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (pv && !pr) begin
                chk($sformatf("c3_hold_data%0d", k), ser_data, pd);
                chk($sformatf("c3_hold_last%0d", k), ser_last, pl);
            end
            ser_ready = (k % 3 == 0);
            if (ser_valid && ser_ready) begin
                acc = {acc[6:0], ser_data};
                nacc++;
                chk($sformatf("c3_last%0d", nacc), ser_last, (nacc == 8));
            end
            pv = ser_valid; pr = ser_ready; pd = ser_data; pl = ser_last;
        end
        chk("c3_count", nacc, 8);
        chk("c3_word", acc, 8'hC3);
        @(negedge clk);
        chk_idle("c3_after");

        // F0 in flight, 0F loaded during 3rd bit
        ser_ready = 1'b1; w = 8'hF0; load = 1'b1; din = w;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("f0_data%0d", i), ser_data, w[7-i]);
            chk($sformatf("f0_last%0d", i), ser_last, (i == 7));
            chk($sformatf("f0_ovr%0d", i), overrun, (i == 3));
            load = (i == 2);
            din  = (i == 2) ? 8'h0F : 8'h00;
        end
        @(negedge clk);
        chk_idle("f0_after");

        // 81 then 7E back-to-back
        w16 = 16'h817E; load = 1'b1; din = 8'h81;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_valid%0d", i), ser_valid, 1'b1);
            chk($sformatf("b2b_data%0d", i), ser_data, w16[15-i]);
            chk($sformatf("b2b_last%0d", i), ser_last, (i == 7 || i == 15));
            chk($sformatf("b2b_ovr%0d", i), overrun, 1'b0);
            load = (i == 7);
            din  = (i == 7) ? 8'h7E : 8'h00;
        end
        @(negedge clk);
        chk_idle("b2b_after");

        // Async reset during 5th bit of FF
        load = 1'b1; din = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            load = 1'b0; din = 8'h00;
            chk($sformatf("ff_data%0d", i), ser_data, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1 chk_idle("async_rst");
        @(negedge clk);
        chk_idle("rst_held");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("post_rst%0d", i));
        end
        w = 8'h01; load = 1'b1; din = w;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            load = 1'b0; din = 8'h00;
            chk($sformatf("x01_data%0d", i), ser_data, w[7-i]);
            chk($sformatf("x01_last%0d", i), ser_last, (i == 7));
        end
        @(negedge clk);
        chk_idle("x01_after");

        // WIDTH=2 instance
        load2 = 1'b1; din2 = 2'b10; ser_ready2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0; din2 = 2'b00;
        chk("w2_b0", {ser_valid2, ser_data2, ser_last2}, 3'b110);
        @(negedge clk);
        chk("w2_b1", {ser_valid2, ser_data2, ser_last2}, 3'b101);
        @(negedge clk);
        chk("w2_after", {ser_valid2, ser_data2, ser_last2, busy2, overrun2}, 5'b00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/day13_serial_readout.md
DAY13_SERIAL_READOUT -- requirements
Module: day13_serial_readout

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per captured word (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 load  input  1  capture strobe; din sampled on a rising edge with load=1 while accepted.
REQ-005 din  input  WIDTH  parallel word to capture.
REQ-006 ser_ready  input  1  downstream consumer accepts current bit.
REQ-007 ser_valid  output  1  ser_data holds a valid bit.
REQ-008 ser_data  output  1  current serial bit, MSB first.
REQ-009 ser_last  output  1  current bit is bit 0 (final bit of word).
REQ-010 busy  output  1  a word is held or being shifted out.
REQ-011 overrun  output  1  one-cycle pulse: load arrived and was dropped.

Function
REQ-012 The block SHALL implement two states: IDLE and SHIFT.
REQ-013 IDLE: ser_valid=0, busy=0, ser_last=0; ser_data SHALL be 0.
REQ-014 IDLE + load=1 at edge: capture din into shift register, bit counter=0, go to SHIFT; ser_valid=1 from the next cycle (latency 1 cycle).
REQ-015 SHIFT: ser_valid=1, busy=1; ser_data = shift register MSB; ser_last=1 exactly when counter = WIDTH-1.
REQ-016 Transfer occurs on an edge with ser_valid=1 and ser_ready=1; only then SHALL the register shift left by one and counter increment.
REQ-017 With ser_valid=1 and ser_ready=0, ser_data and ser_last SHALL hold stable; no bit lost or duplicated.
REQ-018 Transfer with ser_last=1 and load=0: return to IDLE next cycle.
REQ-019 Transfer with ser_last=1 and load=1 same edge: capture din, counter=0, stay in SHIFT (back-to-back, no idle bubble); overrun SHALL stay 0.
REQ-020 load=1 in SHIFT other than REQ-019 case: din ignored, word in flight unaffected, overrun=1 for the following cycle only.
REQ-021 Exactly WIDTH transfers SHALL occur per captured word; counter SHALL never exceed WIDTH-1.
REQ-022 ser_ready while ser_valid=0 SHALL have no effect.
REQ-023 All outputs SHALL be registered or decoded solely from registered state (no combinational path from inputs to outputs).

Reset
REQ-024 rst_n=0 SHALL immediately (without clock) force state=IDLE, shift register=0, counter=0, ser_valid=0, ser_data=0, ser_last=0, busy=0, overrun=0.
REQ-025 Reset mid-word SHALL abandon the word; after rst_n rises, first activity requires a new load.
REQ-026 Edge coinciding with rst_n release: no capture; load takes effect on the next edge.

Verification
REQ-027 WIDTH=8, load din=8'hA5, ser_ready=1 constant -> ser_data 1,0,1,0,0,1,0,1 on 8 consecutive cycles, ser_last only on 8th, busy=0 cycle after.
REQ-028 din=8'hC3, ser_ready toggling 1,0,0,1,... -> ser_data held across ready=0 cycles; accepted sequence 1,1,0,0,0,0,1,1, exactly 8 transfers.
REQ-029 Word 8'hF0 in flight, load din=8'h0F at 3rd bit -> overrun pulses 1 cycle, output remains 8'hF0 sequence, IDLE afterward.
REQ-030 load 8'h81 then load 8'h7E on edge of last transfer -> 16 contiguous valid bits 10000001 01111110, no ser_valid gap, overrun=0.
REQ-031 rst_n=0 asynchronously during 5th bit of 8'hFF -> all outputs 0 immediately; after release, idle until next load; next load 8'h01 shifts correctly.
REQ-032 WIDTH=2, load 2'b10, ser_ready=1 -> ser_data 1 then 0, ser_last on 2nd bit, IDLE after.
